baggage_drop_ctrl: RTL and testbench

Parametrised, clocked successor to the combinational baggage-drop display decoder. Qualifies the `drop_en` request over several cycles, compares actual against limit temperature, issues a fixed-length `drop_activated` pulse, then locks out re-triggering until the request is released. Drives the same four 7-segment digits ("cold", "drop", "hot") plus a lockout pattern. Sits between the temperature/request inputs and the display and drop actuator.

---
 rtl/baggage_drop_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_baggage_drop_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baggage_drop_ctrl.sv
// rtl/baggage_drop_ctrl.sv - clocked baggage-drop controller with qualified request, timed pulse, lockout and 7-segment status
//
// Purpose:
//   Qualifies a level drop request over QUAL_CYCLES cycles, compares the actual
//   temperature against the limit, fires a DROP_CYCLES-long actuator pulse and
//   then locks out re-triggering for at least HOLD_CYCLES cycles and until the
//   request is released. Shows "cold", "drop", " hot" or "----" on four digits.
//
// Ports:
//   clk            in  1      rising-edge clock
//   rst            in  1      synchronous active-high reset
//   t_act          in  WIDTH  actual temperature (unsigned)
//   t_lim          in  WIDTH  limit temperature (unsigned)
//   drop_en        in  1      drop request (level)
//   seven_seg1..4  out 7      digit segments {g,f,e,d,c,b,a}, active-high
//   drop_activated out 1      actuator pulse
//   busy           out 1      high in QUAL, DROP and LOCK
//
// Configuration:
//   BAGGAGE_DROP_HYST_EN  when defined, leaving HOT needs t_lim >= t_act + HYST.

module baggage_drop_ctrl #(
  parameter int WIDTH       = 16,
  parameter int QUAL_CYCLES = 4,
  parameter int DROP_CYCLES = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int HYST        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t_act,
  input  logic [WIDTH-1:0] t_lim,
  input  logic             drop_en,
  output logic [6:0]       seven_seg1,
  output logic [6:0]       seven_seg2,
  output logic [6:0]       seven_seg3,
  output logic [6:0]       seven_seg4,
  output logic             drop_activated,
  output logic             busy
);

  // Parameter sanity; also the only use of HYST when hysteresis is compiled out.
  if (QUAL_CYCLES < 1) begin : g_bad_qual
    $error("QUAL_CYCLES must be >= 1");
  end
  if (DROP_CYCLES < 1) begin : g_bad_drop
    $error("DROP_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (HYST < 0) begin : g_bad_hyst
    $error("HYST must be >= 0");
  end

  localparam int CNT_MAX =
    (QUAL_CYCLES > DROP_CYCLES) ?
      ((QUAL_CYCLES > HOLD_CYCLES) ? QUAL_CYCLES : HOLD_CYCLES) :
      ((DROP_CYCLES > HOLD_CYCLES) ? DROP_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] QUAL_LAST = CW'(QUAL_CYCLES - 1);
  localparam logic [CW-1:0] DROP_LAST = CW'(DROP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  // Segment patterns, concatenated seg1..seg4.
  localparam logic [27:0] SEG_COLD = {7'h39, 7'h5C, 7'h38, 7'h5E};
  localparam logic [27:0] SEG_DROP = {7'h5E, 7'h50, 7'h5C, 7'h73};
  localparam logic [27:0] SEG_HOT  = {7'h00, 7'h76, 7'h5C, 7'h78};
  localparam logic [27:0] SEG_LOCK = {7'h40, 7'h40, 7'h40, 7'h40};

  typedef enum logic [2:0] {
    S_COLD = 3'd0,
    S_QUAL = 3'd1,
    S_DROP = 3'd2,
    S_HOT  = 3'd3,
    S_LOCK = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Compares are done one bit wider so t_act + HYST never wraps.
  logic [WIDTH:0] act_ext;
  logic [WIDTH:0] lim_ext;
  logic [WIDTH:0] exit_thr;
  logic           not_hot;
  logic           cool;

  assign act_ext = {1'b0, t_act};
  assign lim_ext = {1'b0, t_lim};

`ifdef BAGGAGE_DROP_HYST_EN
  assign exit_thr = act_ext + (WIDTH + 1)'(HYST);
`else
  assign exit_thr = act_ext;
`endif

  assign not_hot = (lim_ext >= act_ext);
  assign cool    = (lim_ext >= exit_thr);

  // Registered output word for a state: {seg1, seg2, seg3, seg4, drop_activated, busy}.
  function automatic logic [29:0] outs_for(input state_t s);
    logic [29:0] o;
    o = {SEG_COLD, 1'b0, 1'b0};
    case (s)
      S_COLD:  o = {SEG_COLD, 1'b0, 1'b0};
      S_QUAL:  o = {SEG_COLD, 1'b0, 1'b1};
      S_DROP:  o = {SEG_DROP, 1'b1, 1'b1};
      S_HOT:   o = {SEG_HOT,  1'b0, 1'b0};
      S_LOCK:  o = {SEG_LOCK, 1'b0, 1'b1};
      default: o = {SEG_COLD, 1'b0, 1'b0};
    endcase
    return o;
  endfunction

  // Outputs are loaded together with each state transition so they always
  // match the state register and never see inputs combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_COLD;
      cnt   <= '0;
      {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_COLD);
    end else begin
      case (state)
        S_COLD: begin
          if (drop_en) begin
            state <= S_QUAL;
            cnt   <= '0;
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_QUAL);
          end
        end

        S_QUAL: begin
          if (!drop_en) begin
            state <= S_COLD;
            cnt   <= '0;
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_COLD);
          end else if (cnt == QUAL_LAST) begin
            // Temperatures are only looked at on this final qualifying edge.
            cnt <= '0;
            if (not_hot) begin
              state <= S_DROP;
              {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_DROP);
            end else begin
              state <= S_HOT;
              {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_HOT);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DROP: begin
          // Committed: request and temperatures are ignored until the pulse ends.
          if (cnt == DROP_LAST) begin
            state <= S_LOCK;
            cnt   <= '0;
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_LOCK);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_LOCK: begin
          // cnt saturates at HOLD_LAST; from then on only a released request exits.
          if (cnt != HOLD_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (!drop_en) begin
            state <= S_COLD;
            cnt   <= '0;
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_COLD);
          end
        end

        S_HOT: begin
          if (!drop_en) begin
            state <= S_COLD;
            cnt   <= '0;
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_COLD);
          end else if (cool) begin
            state <= S_QUAL;
            cnt   <= '0;
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_QUAL);
          end
        end

        default: begin
          state <= S_COLD;
          cnt   <= '0;
          {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy} <= outs_for(S_COLD);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// tb/tb_baggage_drop_ctrl.sv - self-checking bench for baggage_drop_ctrl
module tb_baggage_drop_ctrl;

  localparam int Q = 4;
  localparam int D = 8;
  localparam int H = 16;
  localparam int HY = 2;

  localparam logic [27:0] SEG_COLD = {7'h39, 7'h5C, 7'h38, 7'h5E};
  localparam logic [27:0] SEG_DROP = {7'h5E, 7'h50, 7'h5C, 7'h73};
  localparam logic [27:0] SEG_HOT  = {7'h00, 7'h76, 7'h5C, 7'h78};
  localparam logic [27:0] SEG_LOCK = {7'h40, 7'h40, 7'h40, 7'h40};

  localparam logic [29:0] V_IDLE = {SEG_COLD, 1'b0, 1'b0};
  localparam logic [29:0] V_QUAL = {SEG_COLD, 1'b0, 1'b1};
  localparam logic [29:0] V_DROP = {SEG_DROP, 1'b1, 1'b1};
  localparam logic [29:0] V_HOT  = {SEG_HOT,  1'b0, 1'b0};
  localparam logic [29:0] V_LOCK = {SEG_LOCK, 1'b0, 1'b1};

  logic        clk;
  logic        rst;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        drop_en;
  logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;
  logic        drop_activated;
  logic        busy;

  baggage_drop_ctrl #(
    .WIDTH(16), .QUAL_CYCLES(Q), .DROP_CYCLES(D), .HOLD_CYCLES(H), .HYST(HY)
  ) dut (
    .clk(clk), .rst(rst), .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en),
    .seven_seg1(seven_seg1), .seven_seg2(seven_seg2),
    .seven_seg3(seven_seg3), .seven_seg4(seven_seg4),
    .drop_activated(drop_activated), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [29:0] dut_v;
  assign dut_v = {seven_seg1, seven_seg2, seven_seg3, seven_seg4, drop_activated, busy};

  // Reference model: a phase plus a countdown of edges remaining in that phase.
  typedef enum int { P_IDLE, P_QUALIFY, P_PULSE, P_TOO_HOT, P_HOLD } phase_t;
  phase_t m_phase = P_IDLE;
  int     m_left  = 0;

  function automatic logic [29:0] model_v();
    case (m_phase)
      P_QUALIFY: return V_QUAL;
      P_PULSE:   return V_DROP;
      P_TOO_HOT: return V_HOT;
      P_HOLD:    return V_LOCK;
      default:   return V_IDLE;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic en, input int act, input int lim);
    int need;
`ifdef BAGGAGE_DROP_HYST_EN
    need = act + HY;
`else
    need = act;
`endif
    if (r) begin
      m_phase = P_IDLE;
      m_left  = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (en) begin m_phase = P_QUALIFY; m_left = Q; end
        P_QUALIFY: begin
          if (!en) m_phase = P_IDLE;
          else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              if (lim >= act) begin m_phase = P_PULSE; m_left = D; end
              else m_phase = P_TOO_HOT;
            end
          end
        end
        P_PULSE: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = P_HOLD; m_left = H; end
        end
        P_HOLD: begin
          if (m_left > 0) m_left = m_left - 1;
          if (m_left == 0 && !en) m_phase = P_IDLE;
        end
        P_TOO_HOT: begin
          if (!en) m_phase = P_IDLE;
          else if (lim >= need) begin m_phase = P_QUALIFY; m_left = Q; end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // Apply inputs for one cycle, advance the model on the edge, sample 1 ns later.
  task automatic step(input logic r, input logic en, input logic [15:0] act, input logic [15:0] lim);
    rst = r; drop_en = en; t_act = act; t_lim = lim;
    @(posedge clk);
    model_edge(r, en, int'(act), int'(lim));
    #1;
  endtask

  task automatic chk(input string name, input logic [29:0] got, input logic [29:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic mchk(input string name);
    chk(name, dut_v, model_v());
  endtask

  typedef struct {
    logic        r;
    logic        en;
    logic [15:0] act;
    logic [15:0] lim;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int first;
    int n;
    int n_lock;
    logic [29:0] exp_v;

    rst = 1'b1; drop_en = 1'b0; t_act = '0; t_lim = '0;

    vecs[0]  = '{1'b1, 1'b0, 16'd0,   16'd0,   V_IDLE};
    vecs[1]  = '{1'b1, 1'b1, 16'd100, 16'd100, V_IDLE};
    vecs[2]  = '{1'b0, 1'b0, 16'd100, 16'd100, V_IDLE};
    vecs[3]  = '{1'b0, 1'b0, 16'd100, 16'd100, V_IDLE};
    vecs[4]  = '{1'b0, 1'b1, 16'd100, 16'd100, V_QUAL};
    vecs[5]  = '{1'b0, 1'b1, 16'd900, 16'd100, V_QUAL};
    vecs[6]  = '{1'b0, 1'b1, 16'd100, 16'd100, V_QUAL};
    vecs[7]  = '{1'b0, 1'b1, 16'd100, 16'd100, V_QUAL};
    vecs[8]  = '{1'b0, 1'b1, 16'd100, 16'd100, V_DROP};
    vecs[9]  = '{1'b1, 1'b1, 16'd100, 16'd100, V_IDLE};
    vecs[10] = '{1'b0, 1'b1, 16'd60,  16'd50,  V_QUAL};
    vecs[11] = '{1'b0, 1'b1, 16'd60,  16'd50,  V_QUAL};
    vecs[12] = '{1'b0, 1'b1, 16'd60,  16'd50,  V_QUAL};
    vecs[13] = '{1'b0, 1'b1, 16'd60,  16'd50,  V_QUAL};
    vecs[14] = '{1'b0, 1'b1, 16'd60,  16'd50,  V_HOT};
    vecs[15] = '{1'b0, 1'b1, 16'd60,  16'd50,  V_HOT};
    vecs[16] = '{1'b0, 1'b0, 16'd60,  16'd50,  V_IDLE};
    vecs[17] = '{1'b1, 1'b0, 16'd0,   16'd0,   V_IDLE};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].r, vecs[i].en, vecs[i].act, vecs[i].lim);
      chk($sformatf("vec%0d", i), dut_v, vecs[i].exp);
    end

    // Full drop with request held: pulse timing, lockout held until release.
    step(1'b1, 1'b0, 16'd100, 16'd100);
    first = -1; n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 16'd100, 16'd100);
      mchk("held_model");
      if (drop_activated === 1'b1) begin
        if (first < 0) first = i;
        n++;
      end
    end
    chk_int("pulse_start", first, Q);
    chk_int("pulse_len", n, D);
    chk("lock_held", dut_v, V_LOCK);
    step(1'b0, 1'b0, 16'd100, 16'd100);
    chk("lock_release", dut_v, V_IDLE);

    // Release right as the pulse ends: lockout lasts exactly HOLD_CYCLES.
    for (int i = 0; i < Q + D; i++) step(1'b0, 1'b1, 16'd100, 16'd100);
    n_lock = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 16'd100, 16'd100);
      if (dut_v === V_LOCK) n_lock++;
      else break;
    end
    chk_int("hold_len", n_lock, H);
    chk("hold_exit", dut_v, V_IDLE);

    // Hot, then cool down to requalify.
    step(1'b1, 1'b0, 16'd60, 16'd50);
    for (int i = 0; i < Q + 1; i++) step(1'b0, 1'b1, 16'd60, 16'd50);
    chk("hot_entry", dut_v, V_HOT);
`ifdef BAGGAGE_DROP_HYST_EN
    step(1'b0, 1'b1, 16'd50, 16'd50);
    chk("hyst_equal_stays", dut_v, V_HOT);
    step(1'b0, 1'b1, 16'd49, 16'd50);
    chk("hyst_49_stays", dut_v, V_HOT);
    step(1'b0, 1'b1, 16'd48, 16'd50);
`else
    step(1'b0, 1'b1, 16'd50, 16'd50);
`endif
    chk("cool_requal", dut_v, V_QUAL);
    for (int i = 0; i < Q; i++) step(1'b0, 1'b1, 16'd48, 16'd50);
    chk("requal_drop", dut_v, V_DROP);

    // One-cycle glitch low at cnt=2 restarts qualification.
    step(1'b1, 1'b0, 16'd10, 16'd20);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'd10, 16'd20);
    step(1'b0, 1'b0, 16'd10, 16'd20);
    chk("glitch_cold", dut_v, V_IDLE);
    for (int i = 0; i < Q; i++) step(1'b0, 1'b1, 16'd10, 16'd20);
    chk("glitch_still_qual", dut_v, V_QUAL);
    step(1'b0, 1'b1, 16'd10, 16'd20);
    chk("glitch_drop", dut_v, V_DROP);

    // Reset in the middle of a pulse truncates it; next request gets a full pulse.
    step(1'b0, 1'b1, 16'd10, 16'd20);
    step(1'b0, 1'b1, 16'd10, 16'd20);
    step(1'b1, 1'b1, 16'd10, 16'd20);
    chk("rst_mid_drop", dut_v, V_IDLE);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, 16'd10, 16'd20);
      if (drop_activated === 1'b1) n++;
    end
    chk_int("post_rst_pulse_len", n, D);

    // Full-scale boundaries: equality drops; exit compare does not wrap.
    step(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < Q + 1; i++) step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    chk("max_equal_drop", dut_v, V_DROP);
    step(1'b1, 1'b0, 16'hFFFF, 16'hFFFE);
    for (int i = 0; i < Q + 1; i++) step(1'b0, 1'b1, 16'hFFFF, 16'hFFFE);
    chk("max_hot", dut_v, V_HOT);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
`ifdef BAGGAGE_DROP_HYST_EN
    exp_v = V_HOT;
`else
    exp_v = V_QUAL;
`endif
    chk("max_hot_exit", dut_v, exp_v);

    // Randomized run against the reference model.
    step(1'b1, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 8),
           16'(45 + $urandom_range(0, 10)),
           16'(45 + $urandom_range(0, 10)));
      mchk("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
